// File: rtl/common_fifo_dffram_vr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common_fifo_dffram_vr_pkg
// Brief    : Depth and pointer-width helpers shared by the DFF-RAM FIFO files.
// Revision : 1.0 - initial release
// ============================================================================
package common_fifo_dffram_vr_pkg;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // One extra bit above the address distinguishes full from empty.
  function automatic int unsigned fifo_ptr_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/common_dffram.sv
`default_nettype none
// ============================================================================
// Module   : common_dffram
// Brief    : Flop-based RAM, write port A with bit mask, async read port B.
// Revision : 1.0 - initial release
// ============================================================================
module common_dffram
  import common_fifo_dffram_vr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ena,
  input  logic [DATA_WIDTH-1:0] i_wea,
  input  logic [ADDR_WIDTH-1:0] i_addra,
  input  logic [DATA_WIDTH-1:0] i_dina,
  input  logic [ADDR_WIDTH-1:0] i_addrb,
  output logic [DATA_WIDTH-1:0] o_doutb
);

  localparam int c_DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_ena) begin
      r_mem[i_addra] <= (r_mem[i_addra] & ~i_wea) | (i_dina & i_wea);
    end
  end

  // Read is combinational from the array, so a same-edge write is seen next cycle.
  assign o_doutb = r_mem[i_addrb];

endmodule
`default_nettype wire

// File: rtl/common_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : common_fifo_ptr
// Brief    : Wrap-bit FIFO pointer with increment and load, synchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module common_fifo_ptr
  import common_fifo_dffram_vr_pkg::*;
#(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_inc,
  input  logic                                 i_load,
  input  logic [fifo_ptr_width(ADDR_WIDTH)-1:0] i_load_val,
  output logic [fifo_ptr_width(ADDR_WIDTH)-1:0] o_ptr
);

  localparam int c_PTR_W = fifo_ptr_width(ADDR_WIDTH);

  logic [c_PTR_W-1:0] r_ptr;

  // Power-of-two depth: plain binary increment wraps the low bits and toggles the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= r_ptr + c_PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/common_fifo_dffram_vr.sv
`default_nettype none
// ============================================================================
// Module   : common_fifo_dffram_vr
// Brief    : Fall-through valid/ready FIFO on a DFF RAM, with flush and flags.
// Revision : 1.0 - initial release
// ============================================================================
module common_fifo_dffram_vr
  import common_fifo_dffram_vr_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int FIFO_ADDR_WIDTH  = 2,
  parameter int FIFO_AFULL_LEVEL = (1 << FIFO_ADDR_WIDTH) - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [FIFO_DATA_WIDTH-1:0] m_data,
  output logic [FIFO_ADDR_WIDTH:0]   count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full
);

  localparam int                         c_PTR_W   = fifo_ptr_width(FIFO_ADDR_WIDTH);
  localparam logic [c_PTR_W-1:0]         c_AFULL   = c_PTR_W'(FIFO_AFULL_LEVEL);
  localparam logic [FIFO_DATA_WIDTH-1:0] c_WEA_ALL = '1;

  logic [c_PTR_W-1:0] w_wr_ptr;
  logic [c_PTR_W-1:0] w_rd_ptr;
  logic               w_push;
  logic               w_pop;

  // Flags come only from registered pointers, so ready/valid never see s_valid/m_ready.
  assign empty       = (w_wr_ptr == w_rd_ptr);
  assign full        = (w_wr_ptr[FIFO_ADDR_WIDTH-1:0] == w_rd_ptr[FIFO_ADDR_WIDTH-1:0]) &&
                       (w_wr_ptr[FIFO_ADDR_WIDTH] != w_rd_ptr[FIFO_ADDR_WIDTH]);
  assign count       = w_wr_ptr - w_rd_ptr;
  assign almost_full = (count >= c_AFULL);
  assign s_ready     = ~full;
  assign m_valid     = ~empty;

  assign w_push = s_valid & s_ready;
  assign w_pop  = m_valid & m_ready;

  common_fifo_ptr #(
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_wr_ptr (
    .clk        (clk),
    .rst        (reset),
    .i_inc      (w_push & ~flush),
    .i_load     (1'b0),
    .i_load_val (w_wr_ptr),
    .o_ptr      (w_wr_ptr)
  );

  // Flush drops everything queued by moving the read pointer onto the write pointer.
  common_fifo_ptr #(
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_rd_ptr (
    .clk        (clk),
    .rst        (reset),
    .i_inc      (w_pop & ~flush),
    .i_load     (flush),
    .i_load_val (w_wr_ptr),
    .o_ptr      (w_rd_ptr)
  );

  common_dffram #(
    .DATA_WIDTH (FIFO_DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .i_ena   (w_push & ~flush),
    .i_wea   (c_WEA_ALL),
    .i_addra (w_wr_ptr[FIFO_ADDR_WIDTH-1:0]),
    .i_dina  (s_data),
    .i_addrb (w_rd_ptr[FIFO_ADDR_WIDTH-1:0]),
    .o_doutb (m_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_common_fifo_dffram_vr.sv
`default_nettype none
// ============================================================================
// Module   : tb_common_fifo_dffram_vr
// Brief    : Directed self-checking bench for common_fifo_dffram_vr (depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_common_fifo_dffram_vr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;

  int n_checks = 0;
  int n_errors = 0;

  common_fifo_dffram_vr #(
    .FIFO_DATA_WIDTH  (8),
    .FIFO_ADDR_WIDTH  (2),
    .FIFO_AFULL_LEVEL (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},   32'(count),   32'd0);
    chk({tag, "_empty"},   32'(empty),   32'd1);
    chk({tag, "_full"},    32'(full),    32'd0);
    chk({tag, "_mvalid"},  32'(m_valid), 32'd0);
    chk({tag, "_sready"},  32'(s_ready), 32'd1);
    chk({tag, "_afull"},   32'(almost_full), 32'd0);
    chk({tag, "_mdata"},   32'(m_data),  32'h00);
  endtask

  initial begin
    // Reset for two cycles
    reset = 1'b1;
    tick();
    tick();
    chk_reset_state("rst");
    reset = 1'b0;

    // Fill to full
    s_valid = 1'b1;
    s_data = 8'hA1; tick();
    chk("fill1_count", 32'(count), 32'd1);
    chk("fill1_afull", 32'(almost_full), 32'd0);
    chk("fill1_mvalid", 32'(m_valid), 32'd1);
    chk("fill1_mdata", 32'(m_data), 32'hA1);
    s_data = 8'hA2; tick();
    chk("fill2_count", 32'(count), 32'd2);
    chk("fill2_afull", 32'(almost_full), 32'd0);
    s_data = 8'hA3; tick();
    chk("fill3_count", 32'(count), 32'd3);
    chk("fill3_afull", 32'(almost_full), 32'd1);
    chk("fill3_full", 32'(full), 32'd0);
    s_data = 8'hA4; tick();
    chk("fill4_count", 32'(count), 32'd4);
    chk("fill4_full", 32'(full), 32'd1);
    chk("fill4_sready", 32'(s_ready), 32'd0);
    s_data = 8'hFF; tick();
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_mdata", 32'(m_data), 32'hA1);
    s_valid = 1'b0;

    // Drain the four entries in order
    m_ready = 1'b1;
    chk("pop1_mdata", 32'(m_data), 32'hA1); tick();
    chk("pop2_mdata", 32'(m_data), 32'hA2);
    chk("pop2_count", 32'(count), 32'd3);   tick();
    chk("pop3_mdata", 32'(m_data), 32'hA3); tick();
    chk("pop4_mdata", 32'(m_data), 32'hA4); tick();
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // Steady stream 10..19, pointers wrap twice
    s_valid = 1'b1;
    s_data = 8'h10; tick();
    for (int i = 1; i < 10; i++) begin
      chk($sformatf("strm%0d_mdata", i), 32'(m_data), 32'(8'h10 + i - 1));
      chk($sformatf("strm%0d_count", i), 32'(count), 32'd1);
      s_data = 8'(8'h10 + i);
      tick();
    end
    s_valid = 1'b0;
    chk("strm_last_mdata", 32'(m_data), 32'h19);
    chk("strm_last_count", 32'(count), 32'd1);
    tick();
    chk("strm_empty", 32'(empty), 32'd1);
    m_ready = 1'b0;

    // Push into empty: no same-cycle bypass
    s_valid = 1'b1;
    s_data = 8'h55;
    chk("pie_mvalid_now", 32'(m_valid), 32'd0);
    tick();
    s_valid = 1'b0;
    chk("pie_mvalid_next", 32'(m_valid), 32'd1);
    chk("pie_mdata", 32'(m_data), 32'h55);

    // Flush at count 3 with a push and pop offered
    s_valid = 1'b1;
    s_data = 8'h66; tick();
    s_data = 8'h67; tick();
    chk("pre_flush_count", 32'(count), 32'd3);
    s_data = 8'h77;
    m_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    tick();
    chk("flush_hold_count", 32'(count), 32'd0);
    s_valid = 1'b1;
    s_data = 8'h88; tick();
    s_valid = 1'b0;
    chk("post_flush_count", 32'(count), 32'd1);
    chk("post_flush_mdata", 32'(m_data), 32'h88);

    // Reset mid-operation with a push in progress
    s_valid = 1'b1;
    s_data = 8'h99; tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    s_data = 8'hAA;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    s_valid = 1'b0;
    chk_reset_state("midrst");
    tick();
    chk("midrst_hold_count", 32'(count), 32'd0);
    s_valid = 1'b1;
    s_data = 8'hBB; tick();
    s_valid = 1'b0;
    chk("midrst_push_count", 32'(count), 32'd1);
    chk("midrst_push_mdata", 32'(m_data), 32'hBB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
